// File: rtl/sr_mdu.sv
// sr_mdu -- iterative RV32M multiply/divide unit, one bit per clock.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, accepted only in IDLE (flush has priority)
//   flush           synchronous abort back to IDLE, no valid produced
//   oper[2:0]       funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   srcA, srcB      multiplicand/dividend, multiplier/divisor
//   busy            high while in CALC
//   valid           one-cycle pulse in DONE; result valid then
//   result          registered result, held until the next write
//   zero            result == 0
//
// Multiply: shift-add on magnitudes into a 2*WIDTH accumulator, sign fixed
// at the end. Divide: restoring divide on magnitudes, quotient/remainder
// signs fixed at the end. Divide-by-zero and signed overflow finish at
// accept time and skip CALC entirely.
module sr_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Latched request: opcode plus operand signs (sign = signed and negative).
  typedef struct packed {
    logic [2:0] op;
    logic       sa;
    logic       sb;
  } req_t;

  state_t             state, state_nx;
  req_t               req;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;    // product; low half doubles as remainder
  logic [2*WIDTH-1:0] mcand;  // multiplicand, shifted left each step
  logic [WIDTH-1:0]   opb;    // multiplier (shifted right) or divisor (fixed)
  logic [WIDTH-1:0]   dq;     // dividend bits out at MSB, quotient bits in at LSB

  // ---------------- accept-time decode ----------------
  logic             a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0] amag, bmag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] spec_res;
  logic             accept, last;

  always_comb begin
    a_signed = (oper == OP_MULH) || (oper == OP_MULHSU) ||
               (oper == OP_DIV)  || (oper == OP_REM);
    b_signed = (oper == OP_MULH) || (oper == OP_DIV) || (oper == OP_REM);
    neg_a    = a_signed & srcA[WIDTH-1];
    neg_b    = b_signed & srcB[WIDTH-1];
    // Most-negative value negates to itself, which is its correct magnitude.
    amag     = neg_a ? -srcA : srcA;
    bmag     = neg_b ? -srcB : srcB;
    div_zero = oper[2] && (srcB == '0);
    div_ovf  = oper[2] && !oper[0] && (srcA == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (srcB == '1);
    special  = div_zero || div_ovf;
    if (div_zero) spec_res = oper[1] ? srcA : '1;
    else          spec_res = oper[1] ? '0   : srcA;
  end

  assign accept = (state == IDLE) && start && !flush;
  assign last   = (state == CALC) && (cnt == CW'(WIDTH - 1));

  // ---------------- per-step datapath ----------------
  logic [2*WIDTH-1:0] acc_sum, prod;
  logic [WIDTH:0]     sh, diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nx, quo_nx, quo_f, rem_f, fin;

  always_comb begin
    acc_sum = acc + (opb[0] ? mcand : '0);
    prod    = (req.sa ^ req.sb) ? -acc_sum : acc_sum;

    sh      = {acc[WIDTH-1:0], dq[WIDTH-1]};
    diff    = sh - {1'b0, opb};
    q_bit   = !diff[WIDTH];
    rem_nx  = q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    quo_nx  = {dq[WIDTH-2:0], q_bit};
    quo_f   = (req.sa ^ req.sb) ? -quo_nx : quo_nx;
    rem_f   = req.sa ? -rem_nx : rem_nx;

    if (req.op[2])             fin = req.op[1] ? rem_f : quo_f;
    else if (req.op == OP_MUL) fin = prod[WIDTH-1:0];
    else                       fin = prod[2*WIDTH-1:WIDTH];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (last)   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req    <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      dq     <= '0;
      result <= '0;
    end else if (accept) begin
      req    <= '{op: oper, sa: neg_a, sb: neg_b};
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, amag};
      opb    <= bmag;
      dq     <= amag;
      if (special) result <= spec_res;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + CW'(1);
      if (req.op[2]) begin
        acc[WIDTH-1:0] <= rem_nx;
        dq             <= quo_nx;
      end else begin
        acc   <= acc_sum;
        mcand <= mcand << 1;
        opb   <= opb >> 1;
      end
      if (last) result <= fin;
    end
  end

  assign busy  = (state == CALC);
  assign valid = (state == DONE);
  assign zero  = (result == '0);

endmodule

// File: tb/tb_sr_mdu.sv
// Testbench for sr_mdu: directed cases plus randomized operations, checked
// by a scoreboard against an arithmetic reference model.
module tb_sr_mdu;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         start = 0;
  logic         flush = 0;
  logic [2:0]   oper = '0;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         busy, valid, zero;
  logic [W-1:0] result;

  sr_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .oper(oper),
    .srcA(srcA), .srcB(srcB), .busy(busy), .valid(valid), .result(result),
    .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  int           tests = 0;
  int           fails = 0;
  int           issue_cyc = 0;
  logic [W-1:0] last_exp = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions, 64-bit arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint     sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MINV && b == ONES) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return ONES;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == ONES) return '0;
        p = sa % sbv; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return op[2] && (b == 0 || (!op[0] && a == MINV && b == ONES));
  endfunction

  // Monitor: every valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got result %h with nothing expected (cycle %0d)",
                 result, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'b0, zero}, {31'b0, e.res == 0});
        chk("latency", cyc, e.due);
        last_exp = e.res;
      end
    end
  end

  // Drive one start pulse; push the expectation when the op should complete.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push);
    @(posedge clk); #1;
    start = 1; oper = op; srcA = a; srcB = b;
    issue_cyc = cyc;
    if (push) begin
      exp_t e;
      e.res = model(op, a, b);
      e.due = cyc + (is_special(op, a, b) ? 1 : W + 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  // Wait for valid, checking the busy profile on the way.
  task automatic wait_valid(input bit normal);
    bit bad = 0;
    int k;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      k = cyc - issue_cyc;
      if (busy !== (normal && k <= W)) bad = 1;
      if (valid) begin
        chk("busy_profile", {31'b0, bad}, 32'd0);
        return;
      end
    end
    tests++; fails++;
    $display("FAIL timeout: got no valid, expected one within %0d cycles", W + 8);
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b, 1);
    wait_valid(!is_special(op, a, b));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return MINV;
      3: return ONES;
      4: return W'($urandom_range(0, 20));
      5: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    @(posedge clk); #1 rst_n = 1;

    // Directed multiplies / divides
    run(3'd0, 32'd7, 32'hFFFF_FFFD);
    run(3'd1, MINV, MINV);
    run(3'd3, MINV, MINV);
    run(3'd2, MINV, MINV);
    run(3'd3, ONES, ONES);
    run(3'd4, 32'hFFFF_FFF9, 32'd2);
    run(3'd6, 32'hFFFF_FFF9, 32'd2);
    run(3'd5, 32'hFFFF_FFF9, 32'd2);
    run(3'd7, 32'hFFFF_FFF9, 32'd2);

    // Special cases
    run(3'd4, 32'h1234, 32'd0);
    run(3'd7, 32'h1234, 32'd0);
    run(3'd4, MINV, ONES);
    run(3'd6, MINV, ONES);
    run(3'd5, 32'd9, 32'd0);

    // Second start during CALC is ignored (a divide-by-zero would finish early)
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
    while (cyc - issue_cyc < 5) begin @(posedge clk); #1; end
    start = 1; oper = 3'd4; srcA = 32'h55; srcB = 32'd0;
    @(posedge clk); #1 start = 0;
    wait_valid(1);

    // Flush in cycle 10: no valid, result kept
    run(3'd5, 32'd100, 32'd3);
    issue(3'd0, 32'd123, 32'd456, 0);
    while (cyc - issue_cyc < 10) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1 flush = 0;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_result", result, last_exp);

    // Start together with flush in IDLE is dropped
    @(posedge clk); #1;
    start = 1; flush = 1; oper = 3'd4; srcA = 32'd5; srcB = 32'd0;
    @(posedge clk); #1 start = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 chk("startflush_result", result, last_exp);

    // Asynchronous reset mid-divide
    issue(3'd4, 32'd1000, 32'd7, 0);
    repeat (6) @(posedge clk);
    @(negedge clk); #2 rst_n = 0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_valid", {31'b0, valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", {31'b0, zero}, 32'd1);
    @(posedge clk); #1 rst_n = 1;
    last_exp = '0;
    run(3'd5, 32'd100, 32'd7);

    // Randomized back-to-back operations
    for (int n = 0; n < 120; n++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run(op, a, b);
    end

    repeat (4) @(posedge clk);
    #1 chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
